// File: rtl/cprv_lsu.sv
// cprv_lsu: single-outstanding load/store unit behind the RV64I ALU.
// Aligns stores onto byte lanes, extends loads, and rejects misaligned/illegal ops.
module cprv_lsu #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_is_store,
  input  logic [2:0]               ex_funct3,
  input  logic [ADDR_WIDTH-1:0]    ex_addr,
  input  logic [DATA_WIDTH-1:0]    ex_wdata,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [7:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     wb_valid,
  output logic [REGADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     misalign,
  output logic [ADDR_WIDTH-1:0]    misalign_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t                     r_state;
  logic                       r_is_store;
  logic [2:0]                 r_f3;
  logic [2:0]                 r_off;
  logic [REGADDR_WIDTH-1:0]   r_rd;

  logic                       w_accept;
  logic                       w_bad;
  logic [7:0]                 w_be;
  logic [5:0]                 w_wsh;
  logic [5:0]                 w_rsh;
  logic [DATA_WIDTH-1:0]      w_sh;
  logic [DATA_WIDTH-1:0]      w_ld;

  assign ex_ready = (r_state == S_IDLE);
  assign w_accept = ex_valid && ex_ready;
  assign w_wsh    = {ex_addr[2:0], 3'b000};
  assign w_rsh    = {r_off, 3'b000};
  assign w_sh     = mem_rdata >> w_rsh;

  // Misalignment by access size, then illegal funct3 encodings.
  always_comb begin
    w_bad = 1'b0;
    unique case (ex_funct3[1:0])
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = ex_addr[0];
      2'b10:   w_bad = |ex_addr[1:0];
      default: w_bad = |ex_addr[2:0];
    endcase
    if (ex_is_store && ex_funct3[2])
      w_bad = 1'b1;
    if (!ex_is_store && (ex_funct3 == 3'b111))
      w_bad = 1'b1;
  end

  always_comb begin
    w_be = 8'h00;
    unique case (ex_funct3[1:0])
      2'b00:   w_be = 8'h01 << ex_addr[2:0];
      2'b01:   w_be = 8'h03 << ex_addr[2:0];
      2'b10:   w_be = 8'h0F << ex_addr[2:0];
      default: w_be = 8'hFF;
    endcase
  end

  always_comb begin
    w_ld = w_sh;
    unique case (r_f3)
      3'b000:  w_ld = {{(DATA_WIDTH-8){w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ld = {{(DATA_WIDTH-16){w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_ld = {{(DATA_WIDTH-32){w_sh[31]}}, w_sh[31:0]};
      3'b100:  w_ld = {{(DATA_WIDTH-8){1'b0}}, w_sh[7:0]};
      3'b101:  w_ld = {{(DATA_WIDTH-16){1'b0}}, w_sh[15:0]};
      3'b110:  w_ld = {{(DATA_WIDTH-32){1'b0}}, w_sh[31:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_is_store    <= 1'b0;
      r_f3          <= 3'b000;
      r_off         <= 3'b000;
      r_rd          <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= 8'h00;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= ex_is_store;
            r_f3       <= ex_funct3;
            r_off      <= ex_addr[2:0];
            r_rd       <= ex_rd;
            if (w_bad) begin
              misalign      <= 1'b1;
              misalign_addr <= ex_addr;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ex_is_store;
              mem_addr  <= {ex_addr[ADDR_WIDTH-1:3], 3'b000};
              mem_be    <= w_be;
              mem_wdata <= ex_wdata << w_wsh;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_state <= r_is_store ? S_IDLE : S_RESP;
          end
        end
        S_RESP: begin
          // rd==0 still completes the bus access but never writes back.
          if (mem_rvalid) begin
            wb_data  <= w_ld;
            wb_rd    <= r_rd;
            wb_valid <= |r_rd;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_lsu.sv
// tb_cprv_lsu: random + directed load/store traffic against a byte-level
// memory model, with a result scoreboard and a bus responder/monitor.
module tb_cprv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [63:0] ex_addr = '0;
  logic [63:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign;
  logic [63:0] misalign_addr;

  always #5 clk = ~clk;

  cprv_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  typedef struct {
    bit          mis;
    logic [4:0]  rd;
    logic [63:0] val;
  } res_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
  } bus_t;

  res_t        sbq[$];
  bus_t        busq[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  bmem [0:511];
  logic [63:0] dmem [0:63];
  int          force_g = -1;
  int          force_r = -1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic setdw(input logic [63:0] a, input logic [63:0] v);
    int base;
    base = int'(a[8:3]) * 8;
    dmem[a[8:3]] = v;
    for (int i = 0; i < 8; i++) bmem[base + i] = v[8*i +: 8];
  endtask

  task automatic chk_zero();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_misaddr", misalign_addr, 0);
    chk("rst_ready", ex_ready, 1);
  endtask

  // Reference: byte-addressed memory, little-endian assembly and extension.
  task automatic issue(input bit st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [4:0] rd, output int cyc);
    int n, off, k;
    bit badop;
    res_t r;
    bus_t b;
    logic [63:0] v;
    n = 1 << f3[1:0];
    off = int'(a[2:0]);
    badop = ((a % n) != 0) || (st && f3[2]) || (!st && f3 == 3'b111);
    if (badop) begin
      r.mis = 1; r.rd = 0; r.val = a;
      sbq.push_back(r);
    end else begin
      b.addr = a - 64'(off);
      b.be = 8'(((1 << n) - 1) << off);
      b.we = st;
      b.wdata = wd << (8 * off);
      busq.push_back(b);
      if (st) begin
        for (int i = 0; i < n; i++) bmem[int'((a + i) % 512)] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[int'((a + i) % 512)];
        if (!f3[2] && n < 8 && v[8*n-1])
          for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        if (rd != 0) begin
          r.mis = 0; r.rd = rd; r.val = v;
          sbq.push_back(r);
        end
      end
    end
    k = 0;
    while (!ex_ready && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("ready_timeout", 0, 1);
    ex_valid = 1; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(negedge clk);
    ex_valid = 0;
    ex_addr = {$urandom, $urandom};
    ex_wdata = {$urandom, $urandom};
    k = 0;
    while (!ex_ready && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("done_timeout", 0, 1);
    cyc = k + 1;
  endtask

  // Bus responder: checks the request every cycle it is held, then grants.
  initial begin
    bus_t b;
    logic [63:0] rhold;
    bit inreq, rpend;
    int gw, rw;
    inreq = 0; rpend = 0; gw = 0; rw = 0; rhold = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = {$urandom, $urandom};
      if (!rst_n) begin
        inreq = 0;
      end else begin
        if (rpend) begin
          if (rw > 0) rw--;
          else begin mem_rvalid = 1; mem_rdata = rhold; rpend = 0; end
        end else if (!mem_req && ex_ready && $urandom_range(0, 7) == 0) begin
          mem_rvalid = 1;
        end
        if (mem_req) begin
          if (!inreq) begin
            inreq = 1;
            gw = (force_g >= 0) ? force_g : int'($urandom_range(0, 3));
          end
          if (busq.size() == 0) chk("unexpected_req", 1, 0);
          else begin
            b = busq[0];
            chk("bus_addr", mem_addr, b.addr);
            chk("bus_be", mem_be, b.be);
            chk("bus_we", mem_we, b.we);
            if (b.we) chk("bus_wdata", mem_wdata, b.wdata);
          end
          if (gw > 0) gw--;
          else begin
            mem_gnt = 1;
            inreq = 0;
            if (busq.size() != 0) void'(busq.pop_front());
            if (mem_we) begin
              for (int i = 0; i < 8; i++)
                if (mem_be[i]) dmem[mem_addr[8:3]][8*i +: 8] = mem_wdata[8*i +: 8];
            end else begin
              rhold = dmem[mem_addr[8:3]];
              rpend = 1;
              rw = (force_r >= 0) ? force_r : int'($urandom_range(0, 3));
            end
          end
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every writeback or misalign pulse.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (wb_valid || misalign) begin
        if (sbq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = sbq.pop_front();
          if (r.mis) begin
            chk("mis_flag", misalign, 1);
            chk("mis_addr", misalign_addr, r.val);
            chk("mis_nowb", wb_valid, 0);
          end else begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_rd", wb_rd, r.rd);
            chk("wb_data", wb_data, r.val);
            chk("wb_nomis", misalign, 0);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bus_t b;
    logic [2:0] f3;
    logic [63:0] a;
    for (int i = 0; i < 512; i++) bmem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 8; j++) dmem[i][8*j +: 8] = bmem[i*8 + j];

    #1;
    chk_zero();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", ex_ready, 1);

    force_g = 0; force_r = 0;
    setdw(64'h1000, 64'h8877665544332211);
    issue(0, 3'b011, 64'h1000, 0, 5'd1, cyc);
    chk("ld_latency", cyc, 3);
    setdw(64'h1000, 64'h0000000080000000);
    issue(0, 3'b000, 64'h1003, 0, 5'd2, cyc);
    issue(0, 3'b100, 64'h1003, 0, 5'd3, cyc);
    setdw(64'h1000, 64'hF000000000000000);
    issue(0, 3'b010, 64'h1004, 0, 5'd4, cyc);
    issue(0, 3'b110, 64'h1004, 0, 5'd5, cyc);
    issue(0, 3'b011, 64'h1000, 0, 5'd0, cyc);
    force_g = 3;
    issue(1, 3'b001, 64'h2006, 64'h000000000000ABCD, 5'd0, cyc);
    chk("st_free", cyc, 5);
    force_g = 0;
    issue(0, 3'b010, 64'h1002, 0, 5'd6, cyc);
    chk("mis_ready", cyc, 1);
    issue(1, 3'b100, 64'h1000, 0, 5'd0, cyc);
    issue(0, 3'b111, 64'h1000, 0, 5'd7, cyc);

    // Reset while a load waits for rvalid; the late rvalid must be dropped.
    force_r = 8;
    b.addr = 64'h1040; b.be = 8'hFF; b.we = 0; b.wdata = '0;
    busq.push_back(b);
    ex_valid = 1; ex_is_store = 0; ex_funct3 = 3'b011;
    ex_addr = 64'h1040; ex_rd = 5'd9;
    @(negedge clk);
    ex_valid = 0;
    repeat (2) @(negedge clk);
    chk("resp_busy", ex_ready, 0);
    #2 rst_n = 0;
    #1 chk_zero();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_zero();
    repeat (12) @(negedge clk);
    chk("post_rst_wbv", wb_valid, 0);
    force_g = -1; force_r = -1;

    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = 64'h1000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      issue(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom},
            5'($urandom_range(0, 31)), cyc);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("bus_empty", busq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
